// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting one requester per two cycles access to a shared load/increment counter.
// Define COUNTER_ARBITER_SATURATE_EN to make increments saturate at all-ones instead of wrapping.
module counter_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         op_load,
   input  logic [NUM_REQ*WIDTH-1:0]   load_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]           count,
   output logic                       wrap,
   output logic                       busy
);

   localparam int PW = $clog2(NUM_REQ);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state;
   state_t               state_next;
   logic [PW-1:0]        ptr;
   logic [PW-1:0]        ptr_next;
   logic [PW-1:0]        winner;
   logic                 found;
   int                   scan_idx;
   logic [NUM_REQ-1:0]   gnt_next;
   logic [WIDTH-1:0]     count_next;
   logic                 wrap_next;
   logic                 busy_next;

   // Scan from ptr upward, wrapping, and keep the first active requester.
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[scan_idx]) begin
            found  = 1'b1;
            winner = PW'(scan_idx);
         end
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      gnt_next   = '0;
      count_next = count;
      wrap_next  = 1'b0;
      busy_next  = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_next = GRANT;
               gnt_next   = NUM_REQ'(1) << winner;
               busy_next  = 1'b1;
               ptr_next   = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
               if (op_load[winner]) begin
                  count_next = load_data[int'(winner)*WIDTH +: WIDTH];
               end else begin
`ifdef COUNTER_ARBITER_SATURATE_EN
                  if (count != '1) begin
                     count_next = count + WIDTH'(1);
                  end
`else
                  count_next = count + WIDTH'(1);
                  wrap_next  = (count == '1);
`endif
               end
            end
         end
         GRANT: begin
            // Requests seen during GRANT are deliberately ignored.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         gnt   <= '0;
         count <= '0;
         wrap  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         gnt   <= gnt_next;
         count <= count_next;
         wrap  <= wrap_next;
         busy  <= busy_next;
      end
   end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 4, meaning the shared counter width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req, input, NUM_REQ bits: req[i]=1 means requester i requests one counter operation.
REQ-006 Port op_load, input, NUM_REQ bits: op_load[i]=1 means load; 0 means increment.
REQ-007 Port load_data, input, NUM_REQ*WIDTH bits: slice [i*WIDTH +: WIDTH] is requester i's load value.
REQ-008 Port gnt, output, NUM_REQ bits: one-hot grant/acknowledge pulse, registered.
REQ-009 Port count, output, WIDTH bits: shared counter value, registered.
REQ-010 Port wrap, output, 1 bit: one-cycle pulse when an increment wraps from all-ones to zero, registered.
REQ-011 Port busy, output, 1 bit: high while the FSM is in GRANT, registered.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-013 In IDLE with req==0, the FSM SHALL stay in IDLE and hold count, gnt=0, wrap=0.
REQ-014 In IDLE with req!=0, on the next edge it SHALL select one winner w round-robin, starting the search at index ptr and wrapping from NUM_REQ-1 to 0.
REQ-015 On that same edge it SHALL: set gnt to one-hot w; apply w's operation to count; set ptr=(w+1) mod NUM_REQ; set busy=1; enter GRANT.
REQ-016 A load SHALL set count to w's load_data slice; an increment SHALL set count to count+1 modulo 2^WIDTH.
REQ-017 wrap SHALL be 1 for exactly the GRANT cycle of an increment from 2^WIDTH-1 to 0, and 0 otherwise; a load never asserts wrap.
REQ-018 In GRANT, the next edge SHALL clear gnt, wrap and busy and return to IDLE, regardless of req.
REQ-019 Latency: a request sampled in IDLE at edge N SHALL produce gnt and the updated count together after edge N; sustained throughput is one operation per 2 cycles.
REQ-020 Requesters SHALL drop req[i] in the cycle gnt[i] is high; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-021 req changes during GRANT SHALL be ignored; only req sampled in IDLE is arbitrated.
REQ-022 At most one gnt bit SHALL ever be high, and gnt SHALL never be high for two consecutive cycles.
REQ-023 op_load and load_data SHALL be sampled only on the arbitration edge; other values are don't-care.

Reset
REQ-024 With rst=1 at an edge, after that edge: state=IDLE, count=0, gnt=0, wrap=0, busy=0, ptr=0.
REQ-025 Reset SHALL override all activity, including in GRANT; the interrupted operation's count update SHALL be discarded (count=0), and it SHALL NOT be replayed.
REQ-026 The first arbitration after reset deassertion SHALL favour requester 0.

Configuration
REQ-027 The macro COUNTER_ARBITER_SATURATE_EN SHALL select increment behaviour at compile time.
REQ-028 Macro defined: an increment at count=2^WIDTH-1 SHALL leave count at 2^WIDTH-1; wrap SHALL be tied to 0; gnt is still issued.
REQ-029 Macro undefined: increments wrap modulo 2^WIDTH with the wrap pulse per REQ-017.

Verification
REQ-030 Reset, then req=4'b0001 with op_load=0 held 3 grants -> gnt[0] pulses at cycles 1, 3, 5; count goes 1, 2, 3; busy high only in grant cycles.
REQ-031 From reset, req=4'b1111 held, all increments -> grant order 0,1,2,3,0; no bit is granted twice before every other bit is granted once.
REQ-032 req[2]=1, op_load[2]=1, slice 2=4'hA -> after the gnt[2] cycle, count=4'hA and wrap=0.
REQ-033 Load 4'hF, then increment -> without the macro: count=0 and wrap=1 for one cycle; with COUNTER_ARBITER_SATURATE_EN: count stays 4'hF and wrap=0.
REQ-034 Assert rst during a GRANT cycle following a load of 4'h7 -> next cycle count=0, gnt=0, busy=0; next grant with req=4'b1010 goes to requester 1.
REQ-035 Toggle req during GRANT cycles with random values -> no extra grants; gnt is one-hot or zero and never high in back-to-back cycles.
